wall_probe_scheduler: RTL and testbench

Per-frame sequencer that runs wall-collision checks for every tank and bullet through one shared maze-lookup port. At each frame start it snapshots all object positions. It then walks each valid object's four neighbour probes (top, bottom, left, right) and issues one maze read at a time over a req/gnt/rvalid handshake. When the sweep ends it commits per-object wall flags, which the motion logic consumes for the whole next frame.

---
 rtl/wall_probe_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_wall_probe_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_probe_scheduler.sv
// Purpose: per-frame wall-collision sweep; snapshots all objects, probes 4 neighbours each through one maze port.
// Latency: in-bounds probe 3 cycles + stalls, out-of-bounds probe / invalid object 1 cycle, COMMIT 1 cycle, flags+done the cycle after.
// Backpressure: one lookup outstanding; holds maze_req/maze_x/maze_y until maze_gnt, then waits for maze_rvalid.
//
// Ports:
//   pixel_clk, Reset (async, active-low)
//   frame_start            - pulse that starts a sweep (sets overrun if a sweep is already running)
//   obj_valid/x/y/s        - packed per-object participation, centre and half-size (10 bits per object)
//   maze_req/x/y, maze_gnt - lookup request handshake; maze_rvalid/maze_wall return the result
//   wall_top/bottom/left/right - committed flags, held for the whole next frame
//   busy, done, overrun    - sweep in progress, one-cycle commit pulse, sticky frame overlap

module wall_probe_scheduler #(
   parameter int NUM_OBJ  = 4,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                 pixel_clk,
   input  logic                 Reset,
   input  logic                 frame_start,
   input  logic [NUM_OBJ-1:0]   obj_valid,
   input  logic [10*NUM_OBJ-1:0] obj_x,
   input  logic [10*NUM_OBJ-1:0] obj_y,
   input  logic [10*NUM_OBJ-1:0] obj_s,
   output logic                 maze_req,
   output logic [9:0]           maze_x,
   output logic [9:0]           maze_y,
   input  logic                 maze_gnt,
   input  logic                 maze_rvalid,
   input  logic                 maze_wall,
   output logic [NUM_OBJ-1:0]   wall_top,
   output logic [NUM_OBJ-1:0]   wall_bottom,
   output logic [NUM_OBJ-1:0]   wall_left,
   output logic [NUM_OBJ-1:0]   wall_right,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun
);

   localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   typedef enum logic [2:0] {IDLE, PROBE, ISSUE, WAIT, COMMIT} stateT;

   stateT state, nextState;

   // Frame snapshot: the sweep never looks at the live object inputs.
   logic [NUM_OBJ-1:0]    snapValid;
   logic [10*NUM_OBJ-1:0] snapX, snapY, snapS;

   logic [IDX_W-1:0] objIdx;
   logic [1:0]       probeIdx;     // 0 top, 1 bottom, 2 left, 3 right

   logic [NUM_OBJ-1:0] stageTop, stageBottom, stageLeft, stageRight;

   logic [9:0]  curX, curY, curS;
   logic        curValid, lastObj, lastProbe;
   logic [11:0] cx, cy, reach, px, py;
   logic        oob;

   logic skipObj, advance, setFlag, flagVal, loadCoord;

   assign curX      = snapX[10*objIdx +: 10];
   assign curY      = snapY[10*objIdx +: 10];
   assign curS      = snapS[10*objIdx +: 10];
   assign curValid  = snapValid[objIdx];
   assign lastObj   = (objIdx == IDX_W'(NUM_OBJ-1));
   assign lastProbe = (probeIdx == 2'd3);

   assign maze_req = (state == ISSUE);
   assign busy     = (state != IDLE);

   // Probe coordinate with two guard bits: a sum never exceeds 2047, and a
   // negative difference wraps to >= 2048, so a single unsigned compare
   // against the screen limit catches both the negative and the far edge.
   always_comb begin
      cx    = {2'b00, curX};
      cy    = {2'b00, curY};
      reach = {2'b00, curS} + 12'd1;
      px    = cx;
      py    = cy;
      case (probeIdx)
         2'd0:    py = cy - reach;
         2'd1:    py = cy + reach;
         2'd2:    px = cx - reach;
         default: px = cx + reach;
      endcase
      oob = (px > 12'(SCREEN_W-1)) || (py > 12'(SCREEN_H-1));
   end

   always_ff @(posedge pixel_clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      skipObj   = 1'b0;
      advance   = 1'b0;
      setFlag   = 1'b0;
      flagVal   = 1'b0;
      loadCoord = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) nextState = PROBE;
         end
         PROBE: begin
            if (!curValid) begin
               skipObj   = 1'b1;
               nextState = lastObj ? COMMIT : PROBE;
            end else if (oob) begin
               setFlag   = 1'b1;
               flagVal   = 1'b1;
               advance   = 1'b1;
               nextState = (lastProbe && lastObj) ? COMMIT : PROBE;
            end else begin
               loadCoord = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (maze_gnt) nextState = WAIT;
         end
         WAIT: begin
            if (maze_rvalid) begin
               setFlag   = 1'b1;
               flagVal   = maze_wall;
               advance   = 1'b1;
               nextState = (lastProbe && lastObj) ? COMMIT : PROBE;
            end
         end
         COMMIT: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or negedge Reset) begin
      if (!Reset) begin
         snapValid   <= '0;
         snapX       <= '0;
         snapY       <= '0;
         snapS       <= '0;
         objIdx      <= '0;
         probeIdx    <= '0;
         stageTop    <= '0;
         stageBottom <= '0;
         stageLeft   <= '0;
         stageRight  <= '0;
         wall_top    <= '0;
         wall_bottom <= '0;
         wall_left   <= '0;
         wall_right  <= '0;
         maze_x      <= '0;
         maze_y      <= '0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         done <= (state == COMMIT);

         if (frame_start && busy) overrun <= 1'b1;

         if (state == IDLE && frame_start) begin
            snapValid   <= obj_valid;
            snapX       <= obj_x;
            snapY       <= obj_y;
            snapS       <= obj_s;
            objIdx      <= '0;
            probeIdx    <= '0;
            stageTop    <= '0;
            stageBottom <= '0;
            stageLeft   <= '0;
            stageRight  <= '0;
         end

         // Index only moves forward while more objects remain; on the last
         // object the FSM leaves for COMMIT and the index is reloaded next frame.
         if (skipObj && !lastObj) begin
            objIdx   <= objIdx + IDX_W'(1);
            probeIdx <= '0;
         end

         if (advance) begin
            probeIdx <= probeIdx + 2'd1;
            if (lastProbe && !lastObj) objIdx <= objIdx + IDX_W'(1);
         end

         if (setFlag) begin
            case (probeIdx)
               2'd0:    stageTop[objIdx]    <= flagVal;
               2'd1:    stageBottom[objIdx] <= flagVal;
               2'd2:    stageLeft[objIdx]   <= flagVal;
               default: stageRight[objIdx]  <= flagVal;
            endcase
         end

         if (loadCoord) begin
            maze_x <= px[9:0];
            maze_y <= py[9:0];
         end

         if (state == COMMIT) begin
            wall_top    <= stageTop;
            wall_bottom <= stageBottom;
            wall_left   <= stageLeft;
            wall_right  <= stageRight;
         end
      end
   end

endmodule

// File: tb/tb_wall_probe_scheduler.sv
// Purpose: directed bench for wall_probe_scheduler (4-object instance with a stallable maze model,
// plus a 1-object instance with zero-stall maze for the minimum-latency reference).
// Cycle n is the period after rising edge n; frame_start is sampled at edge 0.

module tb_wall_probe_scheduler;

   logic pixel_clk = 1'b0;
   logic Reset;
   always #5 pixel_clk = ~pixel_clk;

   // 4-object instance
   logic        fs;
   logic [3:0]  valid;
   logic [39:0] ox, oy, os;
   logic        req, gnt, rv, wall;
   logic [9:0]  mx, my;
   logic [3:0]  wt, wb, wl, wr;
   logic        busy, done, ovr;

   // 1-object instance
   logic        fs1;
   logic [0:0]  valid1;
   logic [9:0]  ox1, oy1, os1;
   logic        req1, gnt1, rv1, wall1;
   logic [9:0]  mx1, my1;
   logic [0:0]  wt1, wb1, wl1, wr1;
   logic        busy1, done1, ovr1;

   wall_probe_scheduler #(.NUM_OBJ(4)) dut (
      .pixel_clk(pixel_clk), .Reset(Reset), .frame_start(fs),
      .obj_valid(valid), .obj_x(ox), .obj_y(oy), .obj_s(os),
      .maze_req(req), .maze_x(mx), .maze_y(my),
      .maze_gnt(gnt), .maze_rvalid(rv), .maze_wall(wall),
      .wall_top(wt), .wall_bottom(wb), .wall_left(wl), .wall_right(wr),
      .busy(busy), .done(done), .overrun(ovr));

   wall_probe_scheduler #(.NUM_OBJ(1)) dut1 (
      .pixel_clk(pixel_clk), .Reset(Reset), .frame_start(fs1),
      .obj_valid(valid1), .obj_x(ox1), .obj_y(oy1), .obj_s(os1),
      .maze_req(req1), .maze_x(mx1), .maze_y(my1),
      .maze_gnt(gnt1), .maze_rvalid(rv1), .maze_wall(wall1),
      .wall_top(wt1), .wall_bottom(wb1), .wall_left(wl1), .wall_right(wr1),
      .busy(busy1), .done(done1), .overrun(ovr1));

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Maze model for the 4-object instance
   int         nWalls = 0;
   logic [9:0] wX[4], wY[4];
   int         gntStall = 0;
   int         rvDelay  = 1;
   int         grants = 0, oobReq = 0, unstable = 0;

   function automatic logic isWall(input logic [9:0] x, input logic [9:0] y);
      for (int i = 0; i < nWalls; i++)
         if (wX[i] == x && wY[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      int         phase;
      int         wcnt;
      logic [9:0] reqX, reqY;
      gnt = 1'b0; rv = 1'b0; wall = 1'b0;
      phase = 0; wcnt = 0; reqX = '0; reqY = '0;
      forever begin
         @(negedge pixel_clk);
         gnt = 1'b0;
         rv  = 1'b0;
         if (phase == 0) begin
            if (req) begin
               if (wcnt == 0) begin
                  reqX = mx; reqY = my;
               end else if (mx != reqX || my != reqY) begin
                  unstable++;
               end
               if (wcnt >= gntStall) begin
                  gnt = 1'b1; phase = 1; wcnt = 0; grants++;
                  if (mx >= 10'd640 || my >= 10'd480) oobReq++;
               end else begin
                  wcnt++;
               end
            end
         end else begin
            wcnt++;
            if (wcnt >= rvDelay) begin
               rv = 1'b1; wall = isWall(reqX, reqY); phase = 0; wcnt = 0;
            end
         end
      end
   end

   // Zero-stall maze for the 1-object instance: grant always, result the cycle after; wall at (100,95).
   initial begin
      logic pend1, pendWall1;
      gnt1 = 1'b1; rv1 = 1'b0; wall1 = 1'b0; pend1 = 1'b0; pendWall1 = 1'b0;
      forever begin
         @(negedge pixel_clk);
         rv1       = pend1;
         wall1     = pendWall1;
         pend1     = req1;
         pendWall1 = (mx1 == 10'd100 && my1 == 10'd95);
      end
   end

   task automatic setObj(input int i, input int x, input int y, input int s);
      ox[10*i +: 10] = x[9:0];
      oy[10*i +: 10] = y[9:0];
      os[10*i +: 10] = s[9:0];
   endtask

   // Pulses frame_start (edge 0), optionally a second one at cycle ovCyc with
   // altered inputs, and watches until three cycles past the first done.
   task automatic runSweep(input bit one, input int ovCyc, output int doneCyc,
                           output int busyCnt, output int pulses, output logic busyAtDone);
      logic d, b;
      doneCyc = -1; busyCnt = 0; pulses = 0; busyAtDone = 1'bx;
      grants = 0; oobReq = 0; unstable = 0;
      @(negedge pixel_clk);
      if (one) fs1 = 1'b1; else fs = 1'b1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge pixel_clk);
         fs = 1'b0; fs1 = 1'b0;
         if (cyc == ovCyc) begin
            fs = 1'b1; valid = 4'hF; ox = {4{10'd200}};
         end
         d = one ? done1 : done;
         b = one ? busy1 : busy;
         if (d) begin
            pulses++;
            if (doneCyc < 0) begin doneCyc = cyc; busyAtDone = b; end
         end else if (b && doneCyc < 0) begin
            busyCnt++;
         end
         if (doneCyc > 0 && cyc >= doneCyc + 3) break;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dc, bc, np;
      logic bad;
      Reset = 1'b0; fs = 1'b0; fs1 = 1'b0;
      valid = '0; ox = '0; oy = '0; os = '0;
      valid1 = '0; ox1 = '0; oy1 = '0; os1 = '0;
      repeat (2) @(negedge pixel_clk);

      // Reset state
      checkVal("rst_flags",  32'({wt, wb, wl, wr}), 32'd0);
      checkVal("rst_ctrl",   32'({busy, done, req, ovr}), 32'd0);
      checkVal("rst_coord",  32'({mx, my}), 32'd0);
      checkVal("rst1_all",   32'({wt1, wb1, wl1, wr1, busy1, done1, req1, ovr1}), 32'd0);
      Reset = 1'b1;
      repeat (2) @(negedge pixel_clk);

      // Single wall hit, minimum latency: obj (100,100,4), wall at top probe (100,95)
      valid1 = 1'b1; ox1 = 10'd100; oy1 = 10'd100; os1 = 10'd4;
      runSweep(1'b1, 0, dc, bc, np, bad);
      checkVal("t1_done_cyc", 32'(dc), 32'd14);
      checkVal("t1_busy_cycles", 32'(bc), 32'd13);
      checkVal("t1_busy_at_done", 32'(bad), 32'd0);
      checkVal("t1_done_pulses", 32'(np), 32'd1);
      checkVal("t1_flags_tblr", 32'({wt1, wb1, wl1, wr1}), 32'b1000);

      // Screen edges: obj0 (4,240,4) left off-screen; obj1 (635,475,4) bottom/right off-screen.
      // Walls at obj0 top (4,235) and obj1 left (630,475). Lookups: 3 + 2.
      valid = 4'b0011; ox = '0; oy = '0; os = '0;
      setObj(0, 4, 240, 4);
      setObj(1, 635, 475, 4);
      nWalls = 2; wX[0] = 10'd4; wY[0] = 10'd235; wX[1] = 10'd630; wY[1] = 10'd475;
      runSweep(1'b0, 0, dc, bc, np, bad);
      checkVal("t2_done_cyc", 32'(dc), 32'd22);
      checkVal("t2_top",    32'(wt), 32'b0001);
      checkVal("t2_bottom", 32'(wb), 32'b0010);
      checkVal("t2_left",   32'(wl), 32'b0011);
      checkVal("t2_right",  32'(wr), 32'b0010);
      checkVal("t2_grants", 32'(grants), 32'd5);
      checkVal("t2_oob_req", 32'(oobReq), 32'd0);

      // Same frame with grant stalled 5 cycles and result 3 cycles after grant: probe = 10 cycles
      gntStall = 5; rvDelay = 3;
      runSweep(1'b0, 0, dc, bc, np, bad);
      checkVal("t4_done_cyc", 32'(dc), 32'd57);
      checkVal("t4_flags", 32'({wt, wb, wl, wr}), 32'b0001_0010_0011_0010);
      checkVal("t4_grants", 32'(grants), 32'd5);
      checkVal("t4_coord_unstable", 32'(unstable), 32'd0);
      gntStall = 0; rvDelay = 1;

      // Invalid skip: only obj2 valid at (320,240,10), no walls
      valid = 4'b0100; ox = '0; oy = '0; os = '0; nWalls = 0;
      setObj(2, 320, 240, 10);
      runSweep(1'b0, 0, dc, bc, np, bad);
      checkVal("t3_done_cyc", 32'(dc), 32'd17);
      checkVal("t3_flags", 32'({wt, wb, wl, wr}), 32'd0);
      checkVal("t3_grants", 32'(grants), 32'd4);
      checkVal("t3_overrun_clear", 32'(ovr), 32'd0);

      // Overrun: second frame_start at cycle 5 with all objects moved/validated; snapshot must hold
      valid = 4'b0001; ox = '0; oy = '0; os = '0;
      setObj(0, 100, 100, 4);
      nWalls = 1; wX[0] = 10'd100; wY[0] = 10'd95;
      runSweep(1'b0, 5, dc, bc, np, bad);
      checkVal("t5_done_cyc", 32'(dc), 32'd17);
      checkVal("t5_done_pulses", 32'(np), 32'd1);
      checkVal("t5_flags", 32'({wt, wb, wl, wr}), 32'b0001_0000_0000_0000);
      checkVal("t5_overrun", 32'(ovr), 32'd1);
      repeat (5) @(negedge pixel_clk);
      checkVal("t5_overrun_sticky", 32'(ovr), 32'd1);

      // Reset while waiting for a lookup result; the result arrives after release
      valid = 4'b0001; ox = '0; oy = '0; os = '0;
      setObj(0, 100, 100, 4);
      rvDelay = 8;
      @(negedge pixel_clk); fs = 1'b1;
      @(negedge pixel_clk); fs = 1'b0;      // cycle 1: PROBE
      @(negedge pixel_clk);                 // cycle 2: ISSUE, granted
      @(negedge pixel_clk);                 // cycle 3: WAIT
      checkVal("t6_in_wait_busy", 32'(busy), 32'd1);
      Reset = 1'b0;
      #1;
      checkVal("t6_rst_flags", 32'({wt, wb, wl, wr}), 32'd0);
      checkVal("t6_rst_ctrl",  32'({busy, done, req, ovr}), 32'd0);
      checkVal("t6_rst_coord", 32'({mx, my}), 32'd0);
      @(negedge pixel_clk); Reset = 1'b1;
      repeat (12) @(negedge pixel_clk);     // late result lands in cycle 10
      checkVal("t6_late_rv_ignored", 32'({busy, done, req, wt}), 32'd0);
      rvDelay = 1;
      runSweep(1'b0, 0, dc, bc, np, bad);
      checkVal("t6_clean_done_cyc", 32'(dc), 32'd17);
      checkVal("t6_clean_flags", 32'({wt, wb, wl, wr}), 32'b0001_0000_0000_0000);
      checkVal("t6_clean_overrun", 32'(ovr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
